// File: rtl/match_result_uart_tx.sv
// rtl/match_result_uart_tx.sv - serialises SAD match coordinates as a framed 8N1 UART byte stream.
// Define RESULT_CHECKSUM_EN to append an XOR checksum byte to every frame.
module match_result_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  output logic       tx,
  output logic       busy,
  output logic       send_complete,
  output logic       overrun
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
`ifdef RESULT_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [9:0]    x_buf;
  logic [8:0]    y_buf;
  logic [7:0]    cur_byte;
  logic          bit_wrap;
  logic          accept;

  assign bit_wrap = (bit_timer == TIMER_LAST);
  assign accept   = (state == IDLE) && valid;

  // Byte selected by the frame position; only the buffered coordinates feed it.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx)
      3'd0: cur_byte = SYNC_BYTE;
      3'd1: cur_byte = {5'b0, y_buf[8], x_buf[9:8]};
      3'd2: cur_byte = x_buf[7:0];
      3'd3: cur_byte = y_buf[7:0];
`ifdef RESULT_CHECKSUM_EN
      3'd4: cur_byte = {5'b0, y_buf[8], x_buf[9:8]} ^ x_buf[7:0] ^ y_buf[7:0];
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    state_next    = state;
    tx            = 1'b1;
    busy          = 1'b0;
    send_complete = 1'b0;
    case (state)
      IDLE: begin
        if (valid) state_next = START;
      end
      START: begin
        tx   = 1'b0;
        busy = 1'b1;
        if (bit_wrap) state_next = DATA;
      end
      DATA: begin
        tx   = cur_byte[bit_idx];
        busy = 1'b1;
        if (bit_wrap && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        busy = 1'b1;
        if (bit_wrap) state_next = (byte_idx == LAST_BYTE) ? DONE : START;
      end
      DONE: begin
        send_complete = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      x_buf     <= '0;
      y_buf     <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;

      if (busy) bit_timer <= bit_wrap ? '0 : bit_timer + TW'(1);
      else      bit_timer <= '0;

      if (state == IDLE) begin
        bit_idx  <= '0;
        byte_idx <= '0;
      end else begin
        if ((state == DATA) && bit_wrap) bit_idx  <= bit_idx + 3'd1;
        if ((state == STOP) && bit_wrap) byte_idx <= byte_idx + 3'd1;
      end

      if (accept) begin
        x_buf <= x_in;
        y_buf <= y_in;
      end

      // Results arriving mid-frame are dropped; flag it until the next reset.
      if (busy && valid) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_match_result_uart_tx.sv
// tb/tb_match_result_uart_tx.sv - randomized self-checking bench for match_result_uart_tx.
// Honours RESULT_CHECKSUM_EN to expect the five-byte frame.
module tb_match_result_uart_tx;

  localparam int CPB = 4;
`ifdef RESULT_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FRAME = NB * 10 * CPB;

  logic       clock;
  logic       reset;
  logic       valid;
  logic [9:0] x_in;
  logic [8:0] y_in;
  logic       tx;
  logic       busy;
  logic       send_complete;
  logic       overrun;

  int errors;
  int checks;

  match_result_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock),
    .reset(reset),
    .valid(valid),
    .x_in(x_in),
    .y_in(y_in),
    .tx(tx),
    .busy(busy),
    .send_complete(send_complete),
    .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Raises valid for the coming edge; check_frame then follows the frame.
  task automatic start_frame(input logic [9:0] x, input logic [8:0] y);
    @(negedge clock);
    valid = 1'b1;
    x_in  = x;
    y_in  = y;
  endtask

  // Cycle k is the k-th cycle after the accepting edge; DONE is expected at k = FRAME+1.
  task automatic check_frame(input logic [9:0] x, input logic [8:0] y, input string name, input int ovr_at);
    logic [7:0]   eb [5];
    logic [0:199] ev;
    logic [0:199] cv;
    logic [7:0]   db;
    int pos, busy_n, sc_n, sc_k;
    eb[0] = 8'hA5;
    eb[1] = 8'((y / 256) * 4 + (x / 256));
    eb[2] = 8'(x % 256);
    eb[3] = 8'(y % 256);
    eb[4] = eb[1] ^ eb[2] ^ eb[3];
    ev = '0;
    cv = '0;
    pos = 0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin ev[pos] = 1'b0; pos++; end
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < CPB; c++) begin ev[pos] = eb[b][i]; pos++; end
      for (int c = 0; c < CPB; c++) begin ev[pos] = 1'b1; pos++; end
    end
    busy_n = 0;
    sc_n   = 0;
    sc_k   = -1;
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(negedge clock);
      if (k <= FRAME) cv[k-1] = tx;
      busy_n += int'(busy);
      if (send_complete) begin sc_n++; sc_k = k; end
      if (k == 1) begin
        valid = 1'b0;
        x_in  = 10'($urandom);
        y_in  = 9'($urandom);
      end
      if (ovr_at != 0 && k == ovr_at) begin
        checks++;
        if (overrun !== 1'b0) begin
          errors++;
          $display("FAIL %s overrun_before: got %b want 0", name, overrun);
        end
        valid = 1'b1;
        x_in  = 10'd0;
        y_in  = 9'd0;
      end
      if (ovr_at != 0 && k == ovr_at + 1) begin
        valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
          errors++;
          $display("FAIL %s overrun_set: got %b want 1", name, overrun);
        end
      end
    end
    checks++;
    if (cv !== ev) begin
      errors++;
      $display("FAIL %s tx_wave: got %h want %h", name, cv, ev);
    end
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < 8; i++) db[i] = cv[b*10*CPB + (1+i)*CPB + CPB/2];
      checks++;
      if (db !== eb[b]) begin
        errors++;
        $display("FAIL %s byte%0d: got %h want %h", name, b, db, eb[b]);
      end
    end
    checks++;
    if (busy_n != FRAME) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, FRAME);
    end
    checks++;
    if (sc_n != 1 || sc_k != FRAME + 1) begin
      errors++;
      $display("FAIL %s send_complete: got %0d pulses at %0d want 1 at %0d", name, sc_n, sc_k, FRAME + 1);
    end
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle: got tx=%b busy=%b want tx=1 busy=0", name, tx, busy);
    end
  endtask

  task automatic check_idle(input string name, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || send_complete !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s idle: got %0d bad cycles want 0", name, bad);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    valid = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({tx, busy, send_complete, overrun} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_values: got tx,busy,sc,ovr=%b want 1000", {tx, busy, send_complete, overrun});
    end
    reset = 1'b0;
    check_idle("after_reset", 3);
  endtask

  task automatic test_basic;
    start_frame(10'h2C5, 9'h1A3);
    @(negedge clock);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: got tx=%b busy=%b want tx=0 busy=1", tx, busy);
    end
    valid = 1'b0;
    x_in  = 10'($urandom);
    y_in  = 9'($urandom);
    // Remaining FRAME cycles of this frame are checked by restarting the same frame afterwards.
    repeat (FRAME) @(negedge clock);
    check_idle("basic_gap", 2);
    start_frame(10'h2C5, 9'h1A3);
    check_frame(10'h2C5, 9'h1A3, "basic", 0);
    check_idle("basic_tail", 3);
  endtask

  task automatic test_boundary;
    start_frame(10'h3FF, 9'h1FF);
    check_frame(10'h3FF, 9'h1FF, "max", 0);
    check_idle("max_tail", 2);
    start_frame(10'h000, 9'h000);
    check_frame(10'h000, 9'h000, "zero", 0);
    check_idle("zero_tail", 2);
  endtask

  task automatic test_random;
    logic [9:0] x;
    logic [8:0] y;
    for (int n = 0; n < 4; n++) begin
      x = 10'($urandom);
      y = 9'($urandom);
      start_frame(x, y);
      check_frame(x, y, "random", 0);
      check_idle("random_tail", 1 + int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] x;
    logic [8:0] y;
    x = 10'($urandom);
    y = 9'($urandom);
    start_frame(x, y);
    check_frame(x, y, "b2b_first", 0);
    valid = 1'b1;
    x_in  = 10'h3FF;
    y_in  = 9'h1FF;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || send_complete !== 1'b0) begin
      errors++;
      $display("FAIL done_valid_ignored: got tx=%b busy=%b sc=%b want 1 0 0", tx, busy, send_complete);
    end
    x_in = 10'd1;
    y_in = 9'd2;
    check_frame(10'd1, 9'd2, "b2b_second", 0);
    check_idle("b2b_tail", 2);
  endtask

  task automatic test_overrun;
    start_frame(10'h2C5, 9'h1A3);
    check_frame(10'h2C5, 9'h1A3, "overrun", 20);
    check_idle("overrun_tail", 3);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid;
    start_frame(10'h2C5, 9'h1A3);
    for (int k = 1; k <= 95; k++) begin
      @(negedge clock);
      if (k == 1) valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || send_complete !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got tx=%b busy=%b sc=%b ovr=%b want 1 0 0 0", tx, busy, send_complete, overrun);
    end
    reset = 1'b0;
    check_idle("reset_mid_idle", 5);
    start_frame(10'h2C5, 9'h1A3);
    check_frame(10'h2C5, 9'h1A3, "after_reset_mid", 0);
    check_idle("after_reset_mid_tail", 2);
  endtask

  task automatic test_reset_valid;
    @(negedge clock);
    reset = 1'b1;
    valid = 1'b1;
    x_in  = 10'h155;
    y_in  = 9'h0AA;
    @(negedge clock);
    reset = 1'b0;
    valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_wins: got busy=%b tx=%b want busy=0 tx=1", busy, tx);
    end
    check_idle("reset_wins_idle", 4);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_basic;
    test_boundary;
    test_random;
    test_back_to_back;
    test_overrun;
    test_reset_mid;
    test_reset_valid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/match_result_uart_tx.md
Name: match_result_uart_tx

Overview:
- Downstream of the SAD match engine.
- Consumes its single-cycle `valid` strobe with best-match coordinates `x_out[9:0]` and `y_out[8:0]`.
- Packs them into a fixed byte frame and serialises it as 8N1 UART on one pin.
- Returns a one-cycle `send_complete` pulse, which drives the engine's `UARTsendComplete` input.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- valid  input  1  one-cycle strobe: x_in/y_in hold a result
- x_in  input  10  match x coordinate
- y_in  input  9  match y coordinate
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a frame is in flight
- send_complete  output  1  one-cycle pulse after the last stop bit
- overrun  output  1  sticky: valid arrived while busy

Behaviour:
- Reset values:
  - tx=1, busy=0, send_complete=0, overrun=0.
  - FSM=IDLE; all counters 0.
- Accept:
  - In IDLE, `valid`=1 latches x_in/y_in into a frame buffer.
  - busy=1 from the next cycle.
  - tx drives the start bit (0) from the next cycle.
  - Latency valid→tx falling edge is 1 cycle.
- Frame bytes, sent in order:
  - B0=SYNC_BYTE
  - B1={5'b0, y[8], x[9:8]}
  - B2=x[7:0]
  - B3=y[7:0]
- Byte format:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit holds for exactly CLKS_PER_BIT cycles.
  - No idle gap between bytes: the next start bit follows the stop bit immediately.
  - Frame length is 40·CLKS_PER_BIT cycles.
- FSM states: IDLE → START → DATA (8 bits) → STOP.
  - From STOP: go to START if bytes remain, else DONE.
  - DONE → IDLE after one cycle.
- Counters:
  - Bit-timer counts 0..CLKS_PER_BIT-1, wraps, and advances the state/bit index on wrap.
  - Bit index is 3 bits (0..7).
  - Byte index is 3 bits.
- DONE cycle:
  - send_complete=1, busy=0, tx=1.
  - `valid` is ignored in DONE.
  - `valid` is accepted from the following (IDLE) cycle.
- `valid` while busy=1 (START/DATA/STOP):
  - Input is dropped; the buffer is not modified.
  - overrun sets and stays set until reset.
- Inputs are sampled only on the accept cycle. x_in/y_in may change afterward with no effect on tx.
- Reset mid-frame: next edge gives tx=1, busy=0, IDLE, and no send_complete pulse.
- Simultaneous reset and valid: reset wins; nothing is latched.
- send_complete is never asserted outside DONE and is exactly one cycle wide.

Optional Feature:
- Macro: RESULT_CHECKSUM_EN.
- Defined:
  - A 5th byte B4 = B1^B2^B3 is appended after B3.
  - Frame is 50·CLKS_PER_BIT cycles; send_complete follows B4's stop bit.
- Undefined:
  - 4-byte frame; no checksum logic is synthesised.

Test Plan:
- CLKS_PER_BIT=4, reset 2 cycles, then valid with x_in=10'h2C5, y_in=9'h1A3.
  - Required: tx low 1 cycle after valid.
  - Decoded bytes are A5, 06, C5, A3.
  - send_complete pulses exactly once, 161 cycles after valid.
  - busy is high for 160 cycles.
- Same stimulus with RESULT_CHECKSUM_EN defined.
  - Required: 5th byte 0x60.
  - send_complete 201 cycles after valid.
- Second valid (x=0, y=0) 20 cycles into a frame.
  - Required: the frame still decodes A5, 06, C5, A3.
  - overrun=1 from the next cycle and stays 1.
  - Exactly one send_complete.
- Boundary values:
  - x=10'h3FF, y=9'h1FF → A5, 07, FF, FF.
  - x=0, y=0 → A5, 00, 00, 00.
  - Every bit period is exactly 4 cycles.
- valid in the DONE cycle is ignored.
  - valid one cycle later (x=1, y=2) starts a new frame A5, 00, 01, 02.
  - tx shows no glitch between frames.
- reset asserted mid-DATA of B2.
  - Required: tx=1 and busy=0 next cycle; no send_complete.
  - A subsequent valid transmits a complete, correct frame.
